// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the SRAM port arbiter: FSM states, op encoding, line width.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package sram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY_FIRST = 2'd1,
    BUSY       = 2'd2,
    DONE       = 2'd3
  } arb_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } arb_op_t;

  localparam int PERF_W = 32;

  // Read lines are two write words wide.
  function automatic int line_w(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundle of both requester ports plus the SRAM controller side of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: pX_ready low stalls requester X; sram_ready low stalls the arbiter.
interface sram_port_arbiter_if
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int LINE_W = line_w(DATA_W);

  logic              p0_rd_en;
  logic              p0_wr_en;
  logic [ADDR_W-1:0] p0_address;
  logic [DATA_W-1:0] p0_wdata;
  logic [LINE_W-1:0] p0_rdata;
  logic              p0_ready;

  logic              p1_rd_en;
  logic              p1_wr_en;
  logic [ADDR_W-1:0] p1_address;
  logic [DATA_W-1:0] p1_wdata;
  logic [LINE_W-1:0] p1_rdata;
  logic              p1_ready;

  logic              sram_rd_en;
  logic              sram_wr_en;
  logic [ADDR_W-1:0] sram_address;
  logic [DATA_W-1:0] sram_wdata;
  logic [LINE_W-1:0] sram_rdata;
  logic              sram_ready;

  logic              grant;

  // Requesters and SRAM controller side.
  modport master (
    output p0_rd_en, p0_wr_en, p0_address, p0_wdata,
    output p1_rd_en, p1_wr_en, p1_address, p1_wdata,
    output sram_rdata, sram_ready,
    input  p0_rdata, p0_ready, p1_rdata, p1_ready,
    input  sram_rd_en, sram_wr_en, sram_address, sram_wdata, grant
  );

  // Arbiter side.
  modport slave (
    input  p0_rd_en, p0_wr_en, p0_address, p0_wdata,
    input  p1_rd_en, p1_wr_en, p1_address, p1_wdata,
    input  sram_rdata, sram_ready,
    output p0_rdata, p0_ready, p1_rdata, p1_ready,
    output sram_rd_en, sram_wr_en, sram_address, sram_wdata, grant
  );

endinterface

// File: rtl/sram_port_arbiter_rr_picker.sv
// Two-input winner select: round-robin or fixed port-0 priority.
// Latency: winner is combinational; favoured-port pointer updates on the DONE edge.
// Backpressure: none; the caller only consults the winner when it can start a transaction.
module sram_port_arbiter_rr_picker #(
  parameter int FIXED_PRIO = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic req0_i,
  input  logic req1_i,
  input  logic done_i,
  input  logic last_i,
  output logic winner_o
);

  logic ptr_q;
  logic ptr_d;

  // After each completed transaction, favour the port that was not just served.
  always_comb begin
    ptr_d = ptr_q;
    if (done_i) begin
      ptr_d = ~last_i;
    end
  end

  // Pointer register, favours port 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // A lone requester always wins; a tie goes to port 0 or the favoured port.
  always_comb begin
    winner_o = 1'b0;
    if (req0_i && req1_i) begin
      winner_o = (FIXED_PRIO != 0) ? 1'b0 : ptr_q;
    end else if (req1_i) begin
      winner_o = 1'b1;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM controller between dcache (port 0) and ifetch refill (port 1); SRAM_ARB_PERF_CNT_EN adds perf counters.
// Latency: 4 cycles minimum request->pX_ready (IDLE, BUSY_FIRST, BUSY, DONE); BUSY extends until sram_ready.
// Backpressure: a waiting or in-service port sees pX_ready low; sram_ready low holds the access in BUSY.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_port_arbiter_if.slave     bus_io
`ifdef SRAM_ARB_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]      perf_grants0,
  output logic [PERF_W-1:0]      perf_grants1,
  output logic [PERF_W-1:0]      perf_conflict
`endif
);

  localparam int LINE_W = line_w(DATA_W);

  arb_state_t        state_q;
  arb_op_t           op_q;
  logic              grant_q;
  logic              rd_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LINE_W-1:0] p0_rdata_q;
  logic [LINE_W-1:0] p1_rdata_q;

  logic              p0_req;
  logic              p1_req;
  logic              p0_ready;
  logic              p1_ready;
  logic              winner;
  arb_op_t           win_op;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // A request with both enables set is treated as a write.
  assign p0_req    = bus_io.p0_rd_en | bus_io.p0_wr_en;
  assign p1_req    = bus_io.p1_rd_en | bus_io.p1_wr_en;
  assign win_op    = winner ? (bus_io.p1_wr_en ? OP_WR : OP_RD)
                            : (bus_io.p0_wr_en ? OP_WR : OP_RD);
  assign win_addr  = winner ? bus_io.p1_address : bus_io.p0_address;
  assign win_wdata = winner ? bus_io.p1_wdata   : bus_io.p0_wdata;

  // Idle ports are always ready so a dropped request never stalls its pipeline.
  assign p0_ready = ~p0_req | ((state_q == DONE) & ~grant_q);
  assign p1_ready = ~p1_req | ((state_q == DONE) &  grant_q);

  sram_port_arbiter_rr_picker #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_picker (
    .clk      (clk),
    .rst      (rst),
    .req0_i   (p0_req),
    .req1_i   (p1_req),
    .done_i   (state_q == DONE),
    .last_i   (grant_q),
    .winner_o (winner)
  );

  // Request/grant sequencer; all SRAM-facing outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_RD;
      grant_q    <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (p0_req || p1_req) begin
            op_q    <= win_op;
            rd_q    <= (win_op == OP_RD);
            wr_q    <= (win_op == OP_WR);
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
            grant_q <= winner;
            state_q <= BUSY_FIRST;
          end
        end
        // The controller cannot answer in its first cycle, so sram_ready is ignored here.
        BUSY_FIRST: begin
          state_q <= BUSY;
        end
        BUSY: begin
          if (bus_io.sram_ready) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= DONE;
            if (op_q == OP_RD) begin
              if (grant_q) begin
                p1_rdata_q <= bus_io.sram_rdata;
              end else begin
                p0_rdata_q <= bus_io.sram_rdata;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_io.p0_ready     = p0_ready;
  assign bus_io.p1_ready     = p1_ready;
  assign bus_io.p0_rdata     = p0_rdata_q;
  assign bus_io.p1_rdata     = p1_rdata_q;
  assign bus_io.sram_rd_en   = rd_q;
  assign bus_io.sram_wr_en   = wr_q;
  assign bus_io.sram_address = addr_q;
  assign bus_io.sram_wdata   = wdata_q;
  assign bus_io.grant        = grant_q;

`ifdef SRAM_ARB_PERF_CNT_EN
  logic [PERF_W-1:0] perf_grants0_q;
  logic [PERF_W-1:0] perf_grants1_q;
  logic [PERF_W-1:0] perf_conflict_q;
  logic              conflict;

  assign conflict = p0_req & p1_req & ~(p0_ready & p1_ready);

  // Saturating event counters: completions per port and contended cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grants0_q  <= '0;
      perf_grants1_q  <= '0;
      perf_conflict_q <= '0;
    end else begin
      if ((state_q == DONE) && !grant_q && (perf_grants0_q != '1)) begin
        perf_grants0_q <= perf_grants0_q + 1'b1;
      end
      if ((state_q == DONE) && grant_q && (perf_grants1_q != '1)) begin
        perf_grants1_q <= perf_grants1_q + 1'b1;
      end
      if (conflict && (perf_conflict_q != '1)) begin
        perf_conflict_q <= perf_conflict_q + 1'b1;
      end
    end
  end

  assign perf_grants0  = perf_grants0_q;
  assign perf_grants1  = perf_grants1_q;
  assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a scoreboard of expected completions.
// Latency: n/a (testbench).
// Backpressure: a small SRAM model raises sram_ready a set number of cycles after enable.
module tb_sram_port_arbiter;
  import sram_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_rr ();
  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_fx ();

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) dut_rr (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_rr.slave)
  );

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) dut_fx (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_fx.slave)
  );

  // Stimulus is steered to one instance at a time; sel=1 picks the fixed-priority one.
  logic        sel;
  logic        b_rd    [2];
  logic        b_wr    [2];
  logic [31:0] b_addr  [2];
  logic [31:0] b_wdata [2];
  logic        sram_rdy;
  logic [63:0] sram_line;

  assign bus_rr.p0_rd_en   = b_rd[0] & ~sel;
  assign bus_rr.p0_wr_en   = b_wr[0] & ~sel;
  assign bus_rr.p1_rd_en   = b_rd[1] & ~sel;
  assign bus_rr.p1_wr_en   = b_wr[1] & ~sel;
  assign bus_fx.p0_rd_en   = b_rd[0] & sel;
  assign bus_fx.p0_wr_en   = b_wr[0] & sel;
  assign bus_fx.p1_rd_en   = b_rd[1] & sel;
  assign bus_fx.p1_wr_en   = b_wr[1] & sel;
  assign bus_rr.p0_address = b_addr[0];
  assign bus_rr.p1_address = b_addr[1];
  assign bus_fx.p0_address = b_addr[0];
  assign bus_fx.p1_address = b_addr[1];
  assign bus_rr.p0_wdata   = b_wdata[0];
  assign bus_rr.p1_wdata   = b_wdata[1];
  assign bus_fx.p0_wdata   = b_wdata[0];
  assign bus_fx.p1_wdata   = b_wdata[1];
  assign bus_rr.sram_ready = sram_rdy;
  assign bus_fx.sram_ready = sram_rdy;
  assign bus_rr.sram_rdata = sram_line;
  assign bus_fx.sram_rdata = sram_line;

  logic        o_ready [2];
  logic [63:0] o_rdata [2];
  logic        o_srd, o_swr, o_grant;
  logic [31:0] o_saddr, o_swdata;

  assign o_ready[0] = sel ? bus_fx.p0_ready : bus_rr.p0_ready;
  assign o_ready[1] = sel ? bus_fx.p1_ready : bus_rr.p1_ready;
  assign o_rdata[0] = sel ? bus_fx.p0_rdata : bus_rr.p0_rdata;
  assign o_rdata[1] = sel ? bus_fx.p1_rdata : bus_rr.p1_rdata;
  assign o_srd      = sel ? bus_fx.sram_rd_en   : bus_rr.sram_rd_en;
  assign o_swr      = sel ? bus_fx.sram_wr_en   : bus_rr.sram_wr_en;
  assign o_saddr    = sel ? bus_fx.sram_address : bus_rr.sram_address;
  assign o_swdata   = sel ? bus_fx.sram_wdata   : bus_rr.sram_wdata;
  assign o_grant    = sel ? bus_fx.grant        : bus_rr.grant;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  typedef struct packed {
    logic        port;
    logic        is_wr;
    logic [63:0] line;
  } exp_t;

  op_t  pq0[$];
  op_t  pq1[$];
  exp_t sb[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 3;
  bit          always_rdy = 1'b0;
  int          en_cnt = 0;
  int          en_last = 0;
  logic        saw_rd, saw_wr;
  logic [31:0] seen_addr, seen_wdata;
  int          done_cnt [2];
  int          last_done_cyc = 0;
  int          drive_cyc = 0;
  logic [63:0] last_rd [2];

  function automatic logic [63:0] mem_line(input logic [31:0] a);
    if (a == 32'h0000_0100) return 64'hDEAD_BEEF_CAFE_F00D;
    return {~a, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample just after the edge, then update the SRAM controller model.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (o_srd || o_swr) begin
      en_cnt++;
      en_last    = en_cnt;
      saw_rd     = saw_rd | o_srd;
      saw_wr     = saw_wr | o_swr;
      seen_addr  = o_saddr;
      seen_wdata = o_swdata;
    end else begin
      en_cnt = 0;
    end
    sram_rdy  = always_rdy || ((o_srd || o_swr) && (en_cnt >= lat));
    sram_line = mem_line(o_saddr);
  endtask

  task automatic load(input int p);
    op_t o;
    o = '0;
    if (p == 0 && pq0.size() > 0) o = pq0.pop_front();
    else if (p == 1 && pq1.size() > 0) o = pq1.pop_front();
    b_rd[p]    = o.rd;
    b_wr[p]    = o.wr;
    b_addr[p]  = o.addr;
    b_wdata[p] = o.wdata;
  endtask

  task automatic push_op(input int p, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
    op_t o;
    o.rd = rd; o.wr = wr; o.addr = a; o.wdata = d;
    if (p == 0) pq0.push_back(o);
    else pq1.push_back(o);
  endtask

  task automatic expect_done(input int p, input logic is_wr, input logic [31:0] a);
    exp_t e;
    e.port  = (p == 1);
    e.is_wr = is_wr;
    e.line  = is_wr ? 64'h0 : mem_line(a);
    sb.push_back(e);
  endtask

  task automatic complete(input int p);
    exp_t e;
    done_cnt[p]++;
    last_done_cyc = cyc;
    check("done_expected", 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("done_port", 64'(p), 64'(e.port));
      check("grant", 64'(o_grant), 64'(e.port));
      if (!e.is_wr) last_rd[p] = e.line;
      check((p == 1) ? "p1_rdata" : "p0_rdata", o_rdata[p], last_rd[p]);
    end
    load(p);
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
      for (int p = 0; p < 2; p++) begin
        if ((b_rd[p] || b_wr[p]) && o_ready[p]) complete(p);
      end
    end
    check("run_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0;
    rst = 1'b1;
    sram_rdy = 1'b0;
    sram_line = '0;
    saw_rd = 1'b0;
    saw_wr = 1'b0;
    seen_addr = '0;
    seen_wdata = '0;
    for (int p = 0; p < 2; p++) begin
      b_rd[p] = 1'b0; b_wr[p] = 1'b0; b_addr[p] = '0; b_wdata[p] = '0;
      last_rd[p] = '0; done_cnt[p] = 0;
    end
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    check("rst_rd_en", 64'(o_srd), 64'd0);
    check("rst_wr_en", 64'(o_swr), 64'd0);
    check("rst_addr", 64'(o_saddr), 64'd0);
    check("rst_wdata", 64'(o_swdata), 64'd0);
    check("rst_p0_rdata", o_rdata[0], 64'd0);
    check("rst_p1_rdata", o_rdata[1], 64'd0);
    check("rst_grant", 64'(o_grant), 64'd0);
    check("rst_p0_ready", 64'(o_ready[0]), 64'd1);

    // Simultaneous p0 write / p1 read right after reset: p0 first, then p1.
    lat = 2;
    push_op(0, 1'b0, 1'b1, 32'h200, 32'hA5A5_0001);
    push_op(1, 1'b1, 1'b0, 32'h300, 32'h0);
    expect_done(0, 1'b1, 32'h200);
    expect_done(1, 1'b0, 32'h300);
    load(0); load(1);
    run(100);
    tick();

    // p0 read 0x100 alone, ready 3 cycles after enable.
    lat = 3;
    en_last = 0;
    done_cnt[0] = 0;
    push_op(0, 1'b1, 1'b0, 32'h100, 32'h0);
    expect_done(0, 1'b0, 32'h100);
    load(0);
    run(100);
    check("rd_en_cycles", 64'(en_last), 64'd3);
    check("rd_addr", 64'(seen_addr), 64'h100);
    check("p0_done_count", 64'(done_cnt[0]), 64'd1);
    tick(); tick();
    check("p0_rdata_hold", o_rdata[0], 64'hDEAD_BEEF_CAFE_F00D);
    check("p0_ready_idle", 64'(o_ready[0]), 64'd1);

    // Both ports requesting back to back: pointer now favours p1, then alternates.
    lat = 1;
    push_op(0, 1'b1, 1'b0, 32'h10, 32'h0);
    push_op(0, 1'b1, 1'b0, 32'h20, 32'h0);
    push_op(1, 1'b1, 1'b0, 32'h30, 32'h0);
    push_op(1, 1'b1, 1'b0, 32'h40, 32'h0);
    expect_done(1, 1'b0, 32'h30);
    expect_done(0, 1'b0, 32'h10);
    expect_done(1, 1'b0, 32'h40);
    expect_done(0, 1'b0, 32'h20);
    load(0); load(1);
    run(200);
    tick();

    // p1 with both enables set is a write; p1_rdata must not change.
    lat = 2;
    saw_rd = 1'b0;
    saw_wr = 1'b0;
    push_op(1, 1'b1, 1'b1, 32'h500, 32'h1234_5678);
    expect_done(1, 1'b1, 32'h500);
    load(1);
    run(100);
    check("both_en_wr", 64'(saw_wr), 64'd1);
    check("both_en_rd", 64'(saw_rd), 64'd0);
    check("both_en_wdata", 64'(seen_wdata), 64'h1234_5678);
    tick();

    // Reset while a p1 read sits in BUSY: access is discarded.
    lat = 5;
    b_rd[1] = 1'b1;
    b_addr[1] = 32'h800;
    tick();
    tick();
    check("busy_rd_en", 64'(o_srd), 64'd1);
    check("busy_grant", 64'(o_grant), 64'd1);
    rst = 1'b1;
    b_rd[1] = 1'b0;
    tick();
    rst = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    check("midrst_rd_en", 64'(o_srd), 64'd0);
    check("midrst_wr_en", 64'(o_swr), 64'd0);
    check("midrst_p0_rdata", o_rdata[0], 64'd0);
    check("midrst_p1_rdata", o_rdata[1], 64'd0);
    check("midrst_grant", 64'(o_grant), 64'd0);
    lat = 2;
    push_op(0, 1'b1, 1'b0, 32'h600, 32'h0);
    expect_done(0, 1'b0, 32'h600);
    load(0);
    run(100);
    tick();

    // sram_ready stuck high: BUSY_FIRST is still taken, 4-cycle latency.
    always_rdy = 1'b1;
    push_op(0, 1'b1, 1'b0, 32'h700, 32'h0);
    expect_done(0, 1'b0, 32'h700);
    load(0);
    drive_cyc = cyc;
    run(100);
    check("fast_latency", 64'(last_done_cyc - drive_cyc + 1), 64'd4);
    check("fast_en_cycles", 64'(en_last), 64'd2);
    always_rdy = 1'b0;
    tick();
    tick();

    // Fixed priority: p0 wins three times while p1 waits.
    sel = 1'b1;
    lat = 1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    push_op(0, 1'b1, 1'b0, 32'h10, 32'h0);
    push_op(0, 1'b1, 1'b0, 32'h20, 32'h0);
    push_op(0, 1'b1, 1'b0, 32'h30, 32'h0);
    push_op(1, 1'b1, 1'b0, 32'h900, 32'h0);
    expect_done(0, 1'b0, 32'h10);
    expect_done(0, 1'b0, 32'h20);
    expect_done(0, 1'b0, 32'h30);
    load(0); load(1);
    run(200);
    check("fx_p0_done", 64'(done_cnt[0]), 64'd3);
    check("fx_p1_done", 64'(done_cnt[1]), 64'd0);
    check("fx_p1_ready", 64'(o_ready[1]), 64'd0);
    b_rd[1] = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
